// File: rtl/cut_bist_pkg.sv
// Shared types and constants for the CUT BIST sequencer.
package cut_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_IN_W  = 14;
  localparam int DEF_OUT_W = 17;
  localparam int DEF_CNT_W = 16;

  // x^17 + x^3 + 1
  localparam logic [16:0] MISR_POLY = 17'h00009;
  // x^14 + x^5 + x^3 + x + 1 -> feedback from bits 13,4,2,0
  localparam logic [13:0] LFSR_TAPS = 14'h2015;

  // Feedback tap mask for a maximal-length Fibonacci LFSR of width w.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00b8;
      14:      return 32'(LFSR_TAPS);
      16:      return 32'h0000_b400;
      default: return 32'h0000_0003;
    endcase
  endfunction
endpackage

// File: rtl/cut_bist_misr.sv
// Multiple-input signature register: shift-left Galois feedback plus parallel data XOR.
module cut_bist_misr #(
  parameter int               OUT_W = 17,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(9)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] signature
);
  // Compact one response word per enabled cycle; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      signature <= '0;
    else if (en)
      signature <= {signature[OUT_W-2:0], 1'b0}
                 ^ (signature[OUT_W-1] ? POLY : '0)
                 ^ data;
  end
endmodule

// File: rtl/cut_bist_sequencer.sv
// BIST sequencer: drives a combinational CUT with counter/LFSR patterns and
// compacts its responses into a MISR signature compared against a golden value.
module cut_bist_sequencer
  import cut_bist_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] pat_count,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  cut_x,
  input  logic [OUT_W-1:0] cut_f,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass
);
  localparam logic [IN_W-1:0]  TAPS = IN_W'(lfsr_taps(IN_W));
  localparam logic [OUT_W-1:0] POLY = OUT_W'(MISR_POLY);

  state_t           state;
  logic             mode_q;
  logic [OUT_W-1:0] golden_q;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic [IN_W-1:0]  next_x;

  // A start is honoured only outside RUN and only when abort is low.
  assign accept = (state != RUN) && start && !abort;

  // Next pattern: plain up-counter or Fibonacci LFSR, shift-left with parity feedback.
  always_comb begin
    next_x = cut_x + IN_W'(1);
    if (mode_q)
      next_x = {cut_x[IN_W-2:0], ^(cut_x & TAPS)};
  end

  // Control FSM, pattern generator and run-parameter latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      golden_q  <= '0;
      remaining <= '0;
      cut_x     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            mode_q    <= mode;
            golden_q  <= golden;
            remaining <= pat_count;
            // An all-zero seed would lock the LFSR, so substitute 1.
            cut_x     <= (mode && seed == '0) ? IN_W'(1) : seed;
            state     <= (pat_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cut_x     <= next_x;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1))
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cut_bist_misr #(.OUT_W(OUT_W), .POLY(POLY)) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .en        ((state == RUN) && !abort),
    .data      (cut_f),
    .signature (signature)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (signature == golden_q);
endmodule
